cache_control: RTL

//  Control FSM for the direct-mapped, write-back, write-allocate L1 cache (8 lines x 16 B).

---
 rtl/cache_control.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cache_control.sv
// Control FSM for a direct-mapped, write-back, write-allocate L1 cache with a reset-time valid/dirty sweep.
// Define CACHE_PERF_EN to add saturating hit/miss/writeback counters.
module cache_control #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             dirty,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             load_valid,
  output logic             valid_in,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_tag,
  output logic             load_data,
  output logic             data_sel,
  output logic             init_active,
  output logic [IDX_W-1:0] init_index
`ifdef CACHE_PERF_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] sweep_cnt;
  logic             req;

  assign req = mem_read | mem_write;

  // Counter parks at the last index after the sweep; only reset restarts it at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT && sweep_cnt != LAST_IDX)
        sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Outputs are forced low during reset so an open pmem transfer drops immediately.
  always_comb begin
    next_state    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    load_valid    = 1'b0;
    valid_in      = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_tag      = 1'b0;
    load_data     = 1'b0;
    data_sel      = 1'b0;
    init_active   = 1'b0;
    init_index    = '0;
    if (!reset) begin
      unique case (state)
        S_INIT: begin
          init_active = 1'b1;
          init_index  = sweep_cnt;
          load_valid  = 1'b1;
          load_dirty  = 1'b1;
          if (sweep_cnt == LAST_IDX)
            next_state = S_IDLE;
        end
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
              if (mem_write) begin
                load_data  = 1'b1;
                load_dirty = 1'b1;
                dirty_in   = 1'b1;
              end
            end else begin
              next_state = dirty ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp)
            next_state = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_data  = 1'b1;
            data_sel   = 1'b1;
            load_tag   = 1'b1;
            load_valid = 1'b1;
            valid_in   = 1'b1;
            load_dirty = 1'b1;
            next_state = S_IDLE;
          end
        end
        default: next_state = S_INIT;
      endcase
    end
  end

`ifdef CACHE_PERF_EN
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state == S_IDLE) && req && hit;
  assign miss_evt = (state == S_IDLE) && req && !hit;
  assign wb_evt   = (state == S_WRITEBACK) && pmem_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_evt && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (miss_evt && miss_count != '1)
        miss_count <= miss_count + 1'b1;
      if (wb_evt && wb_count != '1)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule
